// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter with a hold-time limit, driving a shared
// single-bit mux output from the current owner's data bit.
module rr_mux_arbiter #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic [3:0] c,
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       valid,
  output logic       z
);

  typedef enum logic {
    IDLE,
    BUSY
  } state_t;

  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  state_t     r_state;
  logic [1:0] r_ptr;
  logic [7:0] r_cnt;
  logic [3:0] r_gnt;
  logic [1:0] r_sel;
  logic       r_valid;

  logic       w_anyReq;
  logic [1:0] w_winner;
  logic       w_release;

  // First set request at or after the pointer, wrapping modulo 4.
  always_comb begin
    logic       found;
    logic [1:0] idx;
    found    = 1'b0;
    idx      = r_ptr;
    w_winner = r_ptr;
    for (int i = 0; i < 4; i++) begin
      idx = r_ptr + 2'(i);
      if (!found && req[idx]) begin
        w_winner = idx;
        found    = 1'b1;
      end
    end
  end

  assign w_anyReq  = |req;
  assign w_release = (r_state == BUSY) && (!req[r_sel] || (r_cnt == HoldLast));

  // The owner is the last candidate in the scan after its own grant, so a
  // timeout hands over to any other requester and re-grants only if alone.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_ptr   <= 2'd0;
      r_cnt   <= 8'd0;
      r_gnt   <= 4'b0000;
      r_sel   <= 2'd0;
      r_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_state <= BUSY;
            r_gnt   <= 4'b0001 << w_winner;
            r_sel   <= w_winner;
            r_valid <= 1'b1;
            r_ptr   <= w_winner + 2'd1;
            r_cnt   <= 8'd0;
          end
        end
        BUSY: begin
          if (w_release) begin
            if (w_anyReq) begin
              r_state <= BUSY;
              r_gnt   <= 4'b0001 << w_winner;
              r_sel   <= w_winner;
              r_valid <= 1'b1;
              r_ptr   <= w_winner + 2'd1;
              r_cnt   <= 8'd0;
            end else begin
              r_state <= IDLE;
              r_gnt   <= 4'b0000;
              r_valid <= 1'b0;
              r_cnt   <= 8'd0;
            end
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state <= IDLE;
          r_gnt   <= 4'b0000;
          r_valid <= 1'b0;
          r_cnt   <= 8'd0;
        end
      endcase
    end
  end

  assign gnt   = r_gnt;
  assign sel   = r_sel;
  assign valid = r_valid;
  assign z     = r_valid ? c[r_sel] : 1'b0;

endmodule

// File: tb/tb_rr_mux_arbiter.sv
// Self-checking bench for rr_mux_arbiter: a MAX_HOLD=4 instance and a
// MAX_HOLD=1 instance share clock and reset.
module tb_rr_mux_arbiter;

  typedef struct {
    logic [3:0] rq;
    logic [3:0] cd;
    logic [3:0] eg;
    logic [1:0] es;
    logic       ev;
    logic       ez;
  } vec_t;

  typedef struct {
    string      name;
    bit         useB;
    logic [7:0] bundle;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req = 4'b0000;
  logic [3:0] c = 4'b0000;
  logic [3:0] req2 = 4'b0000;
  logic [3:0] c2 = 4'b0000;
  logic [3:0] gnt, gntB;
  logic [1:0] sel, selB;
  logic       valid, validB;
  logic       z, zB;

  int checks = 0;
  int errors = 0;
  exp_t sbQueue[$];
  vec_t vecs[12];

  rr_mux_arbiter #(.MAX_HOLD(4)) dutA (
    .clk(clk), .reset(reset), .req(req), .c(c),
    .gnt(gnt), .sel(sel), .valid(valid), .z(z)
  );

  rr_mux_arbiter #(.MAX_HOLD(1)) dutB (
    .clk(clk), .reset(reset), .req(req2), .c(c2),
    .gnt(gntB), .sel(selB), .valid(validB), .z(zB)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] pk(input logic [3:0] g, input logic [1:0] s,
                                    input logic v, input logic zz);
    return {g, s, v, zz};
  endfunction

  task automatic checkVec(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got gnt=%b sel=%b valid=%b z=%b, want gnt=%b sel=%b valid=%b z=%b",
               name, act[7:4], act[3:2], act[1], act[0], exp[7:4], exp[3:2], exp[1], exp[0]);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbQueue.size() == 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard: got empty queue, want an expectation");
    end else begin
      e = sbQueue.pop_front();
      checkVec(e.name, e.useB ? pk(gntB, selB, validB, zB) : pk(gnt, sel, valid, z), e.bundle);
    end
  endtask

  // Called just after a falling edge; compares one cycle later, returns at the next falling edge.
  task automatic applyStimulus(input string name, input bit useB, input logic [3:0] r,
                               input logic [3:0] cc, input logic [7:0] exp);
    exp_t e;
    if (useB) begin
      req2 = r;
      c2   = cc;
    end else begin
      req = r;
      c   = cc;
    end
    e.name   = name;
    e.useB   = useB;
    e.bundle = exp;
    sbQueue.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    @(negedge clk);
  endtask

  // Reset pulse between edges; outputs must clear before any clock edge.
  task automatic doReset(input string name);
    #1 reset = 1'b1;
    #1;
    checkVec(name, pk(gnt, sel, valid, z), 8'h00);
    #1 reset = 1'b0;
    req  = 4'b0000;
    req2 = 4'b0000;
    @(negedge clk);
  endtask

  initial begin
    logic [3:0] cv;
    logic [1:0] o;

    vecs[0]  = '{4'b0100, 4'b0100, 4'b0100, 2'd2, 1'b1, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0100, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[2]  = '{4'b0000, 4'b1111, 4'b0000, 2'd2, 1'b0, 1'b0};
    vecs[3]  = '{4'b0011, 4'b0010, 4'b0001, 2'd0, 1'b1, 1'b0};
    vecs[4]  = '{4'b0011, 4'b0001, 4'b0001, 2'd0, 1'b1, 1'b1};
    vecs[5]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[6]  = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[7]  = '{4'b0010, 4'b0010, 4'b0010, 2'd1, 1'b1, 1'b1};
    vecs[8]  = '{4'b1010, 4'b1000, 4'b0010, 2'd1, 1'b1, 1'b0};
    vecs[9]  = '{4'b1010, 4'b1000, 4'b1000, 2'd3, 1'b1, 1'b1};
    vecs[10] = '{4'b0000, 4'b1000, 4'b0000, 2'd3, 1'b0, 1'b0};
    vecs[11] = '{4'b1111, 4'b0000, 4'b0001, 2'd0, 1'b1, 1'b0};

    // Reset held across a clock edge with requests pending, then released.
    @(negedge clk);
    req = 4'b1111;
    c   = 4'b0101;
    #1;
    checkVec("reset_state", pk(gnt, sel, valid, z), 8'h00);
    checkVec("reset_stateB", pk(gntB, selB, validB, zB), 8'h00);
    @(posedge clk);
    #1;
    checkVec("reset_ignores_clk", pk(gnt, sel, valid, z), 8'h00);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkVec("deassert_no_grant", pk(gnt, sel, valid, z), 8'h00);

    // All four requesting: each owner keeps the grant for exactly 4 cycles.
    cv = 4'b0101;
    for (int i = 0; i < 20; i++) begin
      o = 2'((i / 4) % 4);
      applyStimulus($sformatf("rotate_%0d", i), 1'b0, 4'b1111, cv,
                    pk(4'b0001 << o, o, 1'b1, cv[o]));
    end

    doReset("reset_after_rotate");
    for (int i = 0; i < 12; i++) begin
      applyStimulus($sformatf("vec_%0d", i), 1'b0, vecs[i].rq, vecs[i].cd,
                    pk(vecs[i].eg, vecs[i].es, vecs[i].ev, vecs[i].ez));
    end

    // A lone requester is re-granted on each timeout without a gap.
    doReset("reset_before_lone");
    for (int i = 0; i < 10; i++) begin
      applyStimulus($sformatf("lone_%0d", i), 1'b0, 4'b0100, 4'b0100,
                    pk(4'b0100, 2'd2, 1'b1, 1'b1));
    end

    // Owner drops its request while another waits: handover on the same edge.
    doReset("reset_before_handover");
    applyStimulus("handover_grant0", 1'b0, 4'b0001, 4'b1001, pk(4'b0001, 2'd0, 1'b1, 1'b1));
    applyStimulus("handover_hold0",  1'b0, 4'b1001, 4'b1001, pk(4'b0001, 2'd0, 1'b1, 1'b1));
    applyStimulus("handover_to3",    1'b0, 4'b1000, 4'b1000, pk(4'b1000, 2'd3, 1'b1, 1'b1));
    applyStimulus("handover_idle",   1'b0, 4'b0000, 4'b1000, pk(4'b0000, 2'd3, 1'b0, 1'b0));

    // Mid-grant reset must restart arbitration from pointer 0.
    doReset("reset_before_midgrant");
    applyStimulus("midgrant_own1", 1'b0, 4'b0010, 4'b0010, pk(4'b0010, 2'd1, 1'b1, 1'b1));
    doReset("midgrant_async_clear");
    applyStimulus("midgrant_restart", 1'b0, 4'b1010, 4'b0010, pk(4'b0010, 2'd1, 1'b1, 1'b1));

    // MAX_HOLD=1 instance alternates between its two requesters every cycle.
    doReset("reset_before_hold1");
    for (int i = 0; i < 8; i++) begin
      if (i % 2 == 0)
        applyStimulus($sformatf("hold1_%0d", i), 1'b1, 4'b0101, 4'b0001,
                      pk(4'b0001, 2'd0, 1'b1, 1'b1));
      else
        applyStimulus($sformatf("hold1_%0d", i), 1'b1, 4'b0101, 4'b0001,
                      pk(4'b0100, 2'd2, 1'b1, 1'b0));
    end

    if (sbQueue.size() != 0) begin
      checks++;
      errors++;
      $display("[TB] FAIL scoreboard_drain: got %0d leftover, want 0", sbQueue.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
